// File: rtl/eks_expand_ctrl.sv
// Purpose: Blowfish EKS key-expansion sequencer. XORs the key into P, then chains Feistel calls to refill P and every S-box.
// Latency: start to done = 2 + (P_WORDS/2)(F+2) + (SBOX_NUM*SBOX_DEPTH/2)(F+3) cycles for an F-cycle Feistel engine.
// Backpressure: waits on f_done with no timeout; start is ignored while busy. Optional abort input under `ifdef EKS_ABORT_EN.
module eks_expand_ctrl #(
    parameter int P_WORDS    = 18,
    parameter int SBOX_NUM   = 4,
    parameter int SBOX_DEPTH = 256,
    parameter int AW         = $clog2(SBOX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_l,
`ifdef EKS_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    start,
    input  logic                    use_salt,
    input  logic [127:0]            salt,
    input  logic [32*P_WORDS-1:0]   key,
    input  logic                    p_load,
    input  logic [32*P_WORDS-1:0]   p_init,
    output logic [32*P_WORDS-1:0]   p_out,
    output logic                    f_start,
    output logic [31:0]             f_L,
    output logic [31:0]             f_R,
    input  logic                    f_done,
    input  logic [31:0]             f_resultL,
    input  logic [31:0]             f_resultR,
    output logic                    sb_grant,
    output logic                    sb_cs_l,
    output logic [SBOX_NUM-1:0]     sb_we_l,
    output logic [AW-1:0]           sb_addr,
    output logic [31:0]             sb_wdata,
    output logic                    busy,
    output logic                    done
);

    localparam int NP   = P_WORDS / 2;
    localparam int NJ   = SBOX_DEPTH / 2;
    localparam int PC_W = (NP > 1) ? $clog2(NP) : 1;
    localparam int J_W  = (NJ > 1) ? $clog2(NJ) : 1;
    localparam int K_W  = (SBOX_NUM > 1) ? $clog2(SBOX_NUM) : 1;

    typedef enum logic [3:0] {
        IDLE, XOR_KEY, ENC_P, WAIT_P, WR_P, ENC_S, WAIT_S, WR_SL, WR_SR, DONE
    } state_t;

    state_t               state;
    logic [32*P_WORDS-1:0] p_q;
    logic [31:0]          chain_l;
    logic [31:0]          chain_r;
    logic                 salt_hi;
    logic [PC_W-1:0]      p_idx;
    logic [J_W-1:0]       s_j;
    logic [K_W-1:0]       s_k;
    logic [127:0]         salt_q;
    logic                 use_salt_q;
    logic [31:0]          salt_l;
    logic [31:0]          salt_r;
    logic                 abort_hit;

`ifdef EKS_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign p_out = p_q;

    // Salt halves alternate per Feistel call; salt is captured at start so f_L/f_R cannot move mid-call.
    always_comb begin
        salt_l = '0;
        salt_r = '0;
        if (use_salt_q) begin
            salt_l = salt_hi ? salt_q[95:64]  : salt_q[31:0];
            salt_r = salt_hi ? salt_q[127:96] : salt_q[63:32];
        end
    end

    assign f_L = chain_l ^ salt_l;
    assign f_R = chain_r ^ salt_r;

    // Sequencer: state, P array, chain, counters and all registered strobes (set on entry to the state that owns them).
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= IDLE;
            p_q        <= '0;
            chain_l    <= '0;
            chain_r    <= '0;
            salt_hi    <= 1'b0;
            p_idx      <= '0;
            s_j        <= '0;
            s_k        <= '0;
            salt_q     <= '0;
            use_salt_q <= 1'b0;
            f_start    <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            sb_grant   <= 1'b0;
            sb_cs_l    <= 1'b1;
            sb_we_l    <= '1;
            sb_addr    <= '0;
            sb_wdata   <= '0;
        end else begin
            f_start  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            sb_grant <= 1'b0;
            sb_cs_l  <= 1'b1;
            sb_we_l  <= '1;
            if (abort_hit) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (p_load) begin
                            p_q <= p_init;
                        end else if (start) begin
                            state      <= XOR_KEY;
                            busy       <= 1'b1;
                            salt_q     <= salt;
                            use_salt_q <= use_salt;
                        end
                    end
                    XOR_KEY: begin
                        p_q     <= p_q ^ key;
                        chain_l <= '0;
                        chain_r <= '0;
                        salt_hi <= 1'b0;
                        p_idx   <= '0;
                        s_j     <= '0;
                        s_k     <= '0;
                        state   <= ENC_P;
                        f_start <= 1'b1;
                    end
                    ENC_P: state <= WAIT_P;
                    WAIT_P: begin
                        if (f_done) begin
                            chain_l <= f_resultL;
                            chain_r <= f_resultR;
                            salt_hi <= ~salt_hi;
                            state   <= WR_P;
                        end
                    end
                    WR_P: begin
                        p_q[64*p_idx +: 32]    <= chain_l;
                        p_q[64*p_idx+32 +: 32] <= chain_r;
                        f_start                <= 1'b1;
                        if (p_idx == PC_W'(NP - 1)) begin
                            p_idx <= '0;
                            state <= ENC_S;
                        end else begin
                            p_idx <= p_idx + 1'b1;
                            state <= ENC_P;
                        end
                    end
                    ENC_S: state <= WAIT_S;
                    WAIT_S: begin
                        if (f_done) begin
                            chain_l  <= f_resultL;
                            chain_r  <= f_resultR;
                            salt_hi  <= ~salt_hi;
                            state    <= WR_SL;
                            sb_grant <= 1'b1;
                            sb_cs_l  <= 1'b0;
                            sb_we_l  <= ~(SBOX_NUM'(1) << s_k);
                            sb_addr  <= AW'({s_j, 1'b0});
                            sb_wdata <= f_resultL;
                        end
                    end
                    WR_SL: begin
                        state    <= WR_SR;
                        sb_grant <= 1'b1;
                        sb_cs_l  <= 1'b0;
                        sb_we_l  <= ~(SBOX_NUM'(1) << s_k);
                        sb_addr  <= AW'({s_j, 1'b1});
                        sb_wdata <= chain_r;
                    end
                    WR_SR: begin
                        if (s_j == J_W'(NJ - 1)) begin
                            s_j <= '0;
                            if (s_k == K_W'(SBOX_NUM - 1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                s_k     <= s_k + 1'b1;
                                state   <= ENC_S;
                                f_start <= 1'b1;
                            end
                        end else begin
                            s_j     <= s_j + 1'b1;
                            state   <= ENC_S;
                            f_start <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eks_expand_ctrl.sv
// Bench for eks_expand_ctrl with P_WORDS=4, SBOX_NUM=2, SBOX_DEPTH=4 and a one-cycle Feistel stub.
// Expected P/S contents come from a direct arithmetic walk of the chained-encryption rules.
// Directed cases first, then randomized key/p_init/salt runs, then reset and abort interruptions.
module tb_eks_expand_ctrl;

    localparam int PW = 4;
    localparam int SN = 2;
    localparam int SD = 4;
    localparam int F  = 1;
    // done is counted in cycles after the edge that samples start, hence the -1.
    localparam int EXP_LAT = 2 + (PW/2)*(F+2) + (SN*SD/2)*(F+3) - 1;

    logic              clk = 1'b0;
    logic              reset_l;
    logic              start;
    logic              use_salt;
    logic [127:0]      salt;
    logic [32*PW-1:0]  key;
    logic              p_load;
    logic [32*PW-1:0]  p_init;
    logic [32*PW-1:0]  p_out;
    logic              f_start;
    logic [31:0]       f_L;
    logic [31:0]       f_R;
    logic              f_done = 1'b0;
    logic [31:0]       f_resultL = '0;
    logic [31:0]       f_resultR = '0;
    logic              sb_grant;
    logic              sb_cs_l;
    logic [SN-1:0]     sb_we_l;
    logic [1:0]        sb_addr;
    logic [31:0]       sb_wdata;
    logic              busy;
    logic              done;
`ifdef EKS_ABORT_EN
    logic              abort;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Monitor-owned state
    logic [31:0] sram [0:SN-1][0:SD-1];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          stab_err = 0;
    logic [31:0] fl_q[$];
    logic [31:0] fr_q[$];
    logic [31:0] hold_l;
    logic [31:0] hold_r;
    bit          pend = 0;

    logic [31:0] exp_p [0:PW-1];
    logic [31:0] exp_s [0:SN-1][0:SD-1];

    always #5 clk = ~clk;

    eks_expand_ctrl #(.P_WORDS(PW), .SBOX_NUM(SN), .SBOX_DEPTH(SD)) dut (
        .clk(clk), .reset_l(reset_l),
`ifdef EKS_ABORT_EN
        .abort(abort),
`endif
        .start(start), .use_salt(use_salt), .salt(salt), .key(key),
        .p_load(p_load), .p_init(p_init), .p_out(p_out),
        .f_start(f_start), .f_L(f_L), .f_R(f_R),
        .f_done(f_done), .f_resultL(f_resultL), .f_resultR(f_resultR),
        .sb_grant(sb_grant), .sb_cs_l(sb_cs_l), .sb_we_l(sb_we_l),
        .sb_addr(sb_addr), .sb_wdata(sb_wdata), .busy(busy), .done(done)
    );

    // Feistel stub: F=1, result = {f_L+1, f_R+2}
    always @(posedge clk) begin
        f_done    <= f_start;
        f_resultL <= f_L + 32'd1;
        f_resultR <= f_R + 32'd2;
    end

    // Shadow S-box memory, strobe counters, Feistel input log and stability watch
    always @(posedge clk) begin
        if (!reset_l) begin
            pend = 0;
        end else begin
            if (start && !p_load && busy === 1'b0) begin
                for (int k = 0; k < SN; k++)
                    for (int a = 0; a < SD; a++) sram[k][a] = 'x;
                fl_q.delete();
                fr_q.delete();
            end
            if (sb_cs_l === 1'b0) begin
                wr_cnt++;
                for (int k = 0; k < SN; k++)
                    if (sb_we_l[k] === 1'b0) sram[k][sb_addr] = sb_wdata;
            end
            if (done === 1'b1) done_cnt++;
            if (f_start === 1'b1) begin
                fl_q.push_back(f_L);
                fr_q.push_back(f_R);
                hold_l = f_L;
                hold_r = f_R;
                pend   = 1;
            end else if (pend) begin
                if (f_L !== hold_l || f_R !== hold_r) stab_err++;
                if (f_done) pend = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_p(input logic [127:0] v);
        p_init = v;
        p_load = 1'b1;
        tick();
        p_load = 1'b0;
    endtask

    // Reference: walk the chained encryptions in order, P pairs then S pairs (j before k).
    task automatic model(input logic [127:0] pi, input logic [127:0] k, input bit us, input logic [127:0] sl);
        logic [31:0] l, r, xl, xr;
        bit half;
        int m;
        for (int i = 0; i < PW; i++) exp_p[i] = pi[32*i +: 32] ^ k[32*i +: 32];
        l = '0; r = '0; half = 0;
        for (int i = 0; i < PW/2 + SN*SD/2; i++) begin
            xl = !us ? 32'd0 : (half ? sl[95:64]  : sl[31:0]);
            xr = !us ? 32'd0 : (half ? sl[127:96] : sl[63:32]);
            l = (l ^ xl) + 32'd1;
            r = (r ^ xr) + 32'd2;
            half = !half;
            if (i < PW/2) begin
                exp_p[2*i]   = l;
                exp_p[2*i+1] = r;
            end else begin
                m = i - PW/2;
                exp_s[m/(SD/2)][2*(m%(SD/2))]   = l;
                exp_s[m/(SD/2)][2*(m%(SD/2))+1] = r;
            end
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < PW; i++)
            chk($sformatf("%s P[%0d]", tag, i), 128'(p_out[32*i +: 32]), 128'(exp_p[i]));
        for (int k = 0; k < SN; k++)
            for (int a = 0; a < SD; a++)
                chk($sformatf("%s S%0d[%0d]", tag, k, a), 128'(sram[k][a]), 128'(exp_s[k][a]));
    endtask

    // Launch one expansion and return cycles until done (-1 on timeout); poke exercises XOR_KEY and busy-time p_load/start.
    task automatic expand(input bit poke, output int lat);
        lat   = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (poke && n == 1) chk("xor_key P", p_out, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
            if (poke && n == 5) begin
                p_load = 1'b1;
                p_init = {$urandom, $urandom, $urandom, $urandom};
                start  = 1'b1;
            end
            if (poke && n == 6) begin
                p_load = 1'b0;
                start  = 1'b0;
            end
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        tick();
        chk("done one-shot", {busy, done}, 2'b00);
    endtask

    int   lat;
    int   snap_w;
    int   snap_d;
    logic [127:0] snap_p;
    bit   found;

    initial begin
        reset_l = 1'b0; start = 1'b0; use_salt = 1'b0; salt = '0; key = '0;
        p_load = 1'b0; p_init = '0;
`ifdef EKS_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset strobes", {busy, done, f_start, sb_grant, sb_cs_l, sb_we_l, sb_addr}, {4'b0000, 1'b1, 2'b11, 2'b00});
        chk("reset P", p_out, '0);
        chk("reset wdata", 128'(sb_wdata), 128'h0);
        @(negedge clk);
        reset_l = 1'b1;
        tick();

        // Zero key, zero P, no salt: hand-computed contents
        load_p('0);
        exp_p = '{32'd1, 32'd2, 32'd2, 32'd4};
        exp_s = '{'{32'd3, 32'd6, 32'd4, 32'd8}, '{32'd5, 32'd10, 32'd6, 32'd12}};
        expand(1'b0, lat);
        chk("latency zero", 128'(lat), 128'(EXP_LAT));
        chk("P literal", p_out, 128'h0000_0004_0000_0002_0000_0002_0000_0001);
        check_mem("zero");

        // Salted: first two Feistel inputs 1/2 then 1/0
        use_salt = 1'b1;
        salt = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
        load_p('0);
        expand(1'b0, lat);
        chk("salt fstarts", 128'(fl_q.size()), 128'(PW/2 + SN*SD/2));
        chk("salt fL0", 128'(fl_q[0]), 128'd1);
        chk("salt fR0", 128'(fr_q[0]), 128'd2);
        chk("salt fL1", 128'(fl_q[1]), 128'd1);
        chk("salt fR1", 128'(fr_q[1]), 128'd0);
        model('0, '0, 1'b1, salt);
        check_mem("salt");

        // Key word 0 all ones; p_load and start while busy must be ignored
        use_salt = 1'b0;
        key = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
        load_p('0);
        snap_d = done_cnt;
        expand(1'b1, lat);
        repeat (30) tick();
        chk("busy start ignored", 128'(done_cnt - snap_d), 128'd1);
        chk("latency key", 128'(lat), 128'(EXP_LAT));
        model('0, key, 1'b0, '0);
        check_mem("key");

        // Randomized runs
        for (int it = 0; it < 6; it++) begin
            logic [127:0] pi;
            pi       = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            salt     = {$urandom, $urandom, $urandom, $urandom};
            use_salt = 1'($urandom_range(0, 1));
            load_p(pi);
            expand(1'b0, lat);
            chk($sformatf("latency rnd%0d", it), 128'(lat), 128'(EXP_LAT));
            model(pi, key, use_salt, salt);
            check_mem($sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of WR_SL
        key = '0; use_salt = 1'b0;
        load_p(128'h1234);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (sb_cs_l === 1'b0 && sb_addr[0] === 1'b0) begin
                found = 1;
                break;
            end
        end
        chk("reach WR_SL", 128'(found), 128'd1);
        snap_w = wr_cnt;
        #2 reset_l = 1'b0;
        #1;
        chk("midreset strobes", {busy, done, f_start, sb_grant, sb_cs_l, sb_we_l, sb_addr}, {4'b0000, 1'b1, 2'b11, 2'b00});
        chk("midreset P", p_out, '0);
        chk("midreset wdata", 128'(sb_wdata), 128'h0);
        @(negedge clk);
        reset_l = 1'b1;
        repeat (30) tick();
        chk("no writes after reset", 128'(wr_cnt - snap_w), 128'd0);
        chk("idle after reset", 128'(busy), 128'd0);

`ifdef EKS_ABORT_EN
        // Abort while waiting on an S-phase Feistel result
        load_p(128'h55);
        snap_d = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (wr_cnt - snap_w >= 2 && f_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("reach ENC_S", 128'(found), 128'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort idle", 128'(busy), 128'd0);
        snap_w = wr_cnt;
        snap_p = p_out;
        repeat (40) tick();
        chk("abort no writes", 128'(wr_cnt - snap_w), 128'd0);
        chk("abort no done", 128'(done_cnt - snap_d), 128'd0);
        chk("abort P kept", p_out, snap_p);
`endif

        chk("f_L/f_R stable in flight", 128'(stab_err), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
